// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the set-associative icache.
//   - idx_w / woff_w / tag_w : address field widths derived from SETS and WORDS
//   - frame_t                : per-way lookup frame (valid + tag, tag zero-extended)
//   - state_t                : fill state machine encoding
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Tag is carried at full address width so one frame type serves every
   // parameter set; stored tags are zero-extended into it.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
   } frame_t;

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int woff_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int tag_w(input int sets, input int words);
      return 30 - idx_w(sets) - woff_w(words);
   endfunction

endpackage

// File: rtl/icache_plru.sv
// icache_plru: per-set replacement state.
//   CLK, RST    : clock, synchronous active-high reset
//   clear       : return every set to the reset state (cache flush)
//   rd_idx      : set being looked up; victim is that set's replacement choice
//   upd_en      : mark upd_way of set upd_idx most-recently-used
// WAYS=1 keeps no state, WAYS=2 is true LRU, WAYS=4 is tree pseudo-LRU.
module icache_plru #(
   parameter int SETS = 8,
   parameter int WAYS = 2,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WAY_W-1:0] victim,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [WAY_W-1:0] upd_way
);

   generate
      if (WAYS == 1) begin : g_dm
         assign victim = '0;
         logic unused_plru;
         assign unused_plru = ^{CLK, RST, clear, rd_idx, upd_en, upd_idx, upd_way};
      end else if (WAYS == 2) begin : g_lru
         // Bit holds the least-recently-used way of the set.
         logic [SETS-1:0] lru;
         always_ff @(posedge CLK) begin
            if (RST || clear)
               lru <= '0;
            else if (upd_en)
               lru[upd_idx] <= ~upd_way[0];
         end
         assign victim = lru[rd_idx];
      end else begin : g_tree
         // bit0: 0 -> victim in ways 0/1, 1 -> ways 2/3
         // bit1: victim within 0/1, bit2: victim within 2/3
         logic [2:0] tree [SETS];
         logic [2:0] cur;
         always_ff @(posedge CLK) begin
            if (RST || clear) begin
               for (int s = 0; s < SETS; s++) tree[s] <= '0;
            end else if (upd_en) begin
               tree[upd_idx][0] <= ~upd_way[1];
               if (!upd_way[1]) tree[upd_idx][1] <= ~upd_way[0];
               else             tree[upd_idx][2] <= ~upd_way[0];
            end
         end
         assign cur    = tree[rd_idx];
         assign victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
      end
   endgenerate

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: parametrised set-associative instruction cache.
//   Datapath side: imemREN/imemaddr in, ihit/imemload out (hit same cycle),
//                  iflush invalidates every line in one cycle.
//   Memory side:   iREN/iaddr out, iwait/iload in; a miss fetches the whole
//                  block word by word, then the re-lookup hits.
//   CLK rising edge, RST synchronous active-high.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        iflush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int IDX_W  = idx_w(SETS);
   localparam int WOFF_W = woff_w(WORDS);
   localparam int TAG_W  = tag_w(SETS, WORDS);
   localparam int CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LO     = 2 + WOFF_W;
   localparam logic [31:0] BLK_MASK = (32'd1 << LO) - 32'd1;

   // address fields of the current lookup
   logic [IDX_W-1:0] a_idx;
   logic [TAG_W-1:0] a_tag;
   logic [CNT_W-1:0] a_woff;
   logic             unused_addr;

   assign a_idx       = imemaddr[LO +: IDX_W];
   assign a_tag       = imemaddr[31 -: TAG_W];
   assign unused_addr = ^imemaddr[1:0];

   generate
      if (WOFF_W > 0) begin : g_woff
         assign a_woff = imemaddr[2 +: WOFF_W];
      end else begin : g_woff0
         assign a_woff = '0;
      end
   endgenerate

   // storage: only valid bits are reset
   logic [WAYS-1:0]  valid [SETS];
   logic [TAG_W-1:0] tags  [SETS][WAYS];
   logic [31:0]      data  [SETS][WAYS][WORDS];

   // fill context latched at the miss
   state_t           state, nxt;
   logic [31:0]      base;
   logic [WAY_W-1:0] fill_way;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;

   assign f_idx = base[LO +: IDX_W];
   assign f_tag = base[31 -: TAG_W];

   // lookup
   frame_t           frame [WAYS];
   logic             hit_any;
   logic [WAY_W-1:0] hit_way;

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         frame[w] = '{valid: valid[a_idx][w], tag: 32'(tags[a_idx][w])};
         if (frame[w].valid && frame[w].tag == 32'(a_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // victim: lowest invalid way first, replacement policy otherwise
   logic [WAY_W-1:0] plru_victim, victim;
   logic             found;

   always_comb begin
      victim = plru_victim;
      found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid[a_idx][w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
   end

   // flush suppresses both the hit and a new fill in the same cycle
   logic lookup, hit, miss, beat, last;

   assign lookup = (state == IDLE) && imemREN && !iflush && !RST;
   assign hit    = lookup && hit_any;
   assign miss   = lookup && !hit_any;
   assign beat   = (state == FILL) && !iwait && !iflush && !RST;
   assign last   = beat && (cnt == CNT_W'(WORDS - 1));

   icache_plru #(.SETS(SETS), .WAYS(WAYS)) u_plru (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (iflush),
      .rd_idx  (a_idx),
      .victim  (plru_victim),
      .upd_en  (hit || last),
      .upd_idx (hit ? a_idx : f_idx),
      .upd_way (hit ? hit_way : fill_way)
   );

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   // FSM: next state
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (miss) nxt = FILL;
         FILL:    if (iflush || last) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ihit     = hit;
      imemload = hit ? data[a_idx][hit_way][a_woff] : '0;
      iREN     = (state == FILL);
      iaddr    = iREN ? base + (32'(cnt) << 2) : '0;
   end

   // fill context
   always_ff @(posedge CLK) begin
      if (RST) begin
         base     <= '0;
         fill_way <= '0;
         cnt      <= '0;
      end else if (miss) begin
         base     <= imemaddr & ~BLK_MASK;
         fill_way <= victim;
         cnt      <= '0;
      end else if (beat && !last) begin
         cnt      <= cnt + CNT_W'(1);
      end
   end

   // victim is invalidated up front so an aborted fill never leaves a
   // half-written line visible
   always_ff @(posedge CLK) begin
      if (RST || iflush) begin
         for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end else if (miss) begin
         valid[a_idx][victim] <= 1'b0;
      end else if (last) begin
         valid[f_idx][fill_way] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (beat) data[f_idx][fill_way][cnt] <= iload;
      if (last) tags[f_idx][fill_way]      <= f_tag;
   end

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;

   logic        CLK = 1'b0;
   logic        RST, imemREN, iflush, iwait;
   logic [31:0] imemaddr, iload, imemload, iaddr;
   logic        ihit, iREN;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload)
   );

   // backing memory: content is a fixed function of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hAAAA, a[15:0]};
   endfunction

   assign iload = mem_word(iaddr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model: which blocks are resident and when each way was last used
   bit          mvalid  [SETS][WAYS];
   int unsigned mtag    [SETS][WAYS];
   int unsigned used_at [SETS][WAYS];
   int unsigned stamp = 1;

   function automatic int set_of(input logic [31:0] a);
      return int'((a / (4 * WORDS)) % SETS);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a / (4 * WORDS * SETS);
   endfunction

   function automatic int m_lookup(input logic [31:0] a);
      int s = set_of(a);
      for (int w = 0; w < WAYS; w++)
         if (mvalid[s][w] && mtag[s][w] == tag_of(a)) return w;
      return -1;
   endfunction

   function automatic void m_touch(input int s, input int w);
      used_at[s][w] = stamp;
      stamp++;
   endfunction

   function automatic int m_victim(input int s);
      int v = 0;
      for (int w = 0; w < WAYS; w++) if (!mvalid[s][w]) return w;
      for (int w = 1; w < WAYS; w++) if (used_at[s][w] < used_at[s][v]) v = w;
      return v;
   endfunction

   function automatic void m_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            mvalid[s][w]  = 1'b0;
            used_at[s][w] = 0;
         end
   endfunction

   // One fetch. stall<0: random iwait; stall>=0: that many wait cycles before
   // each beat. chg!=0: after the first beat move imemaddr there and drop imemREN.
   task automatic do_fetch(input logic [31:0] a, input int stall, input logic [31:0] chg);
      int s, w, v, beat, cyc;
      logic [31:0] base;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b0;
      #1;
      s = set_of(a);
      w = m_lookup(a);
      if (w >= 0) begin
         chk("hit", ihit, 1);
         chk("hit_data", imemload, mem_word(a & ~32'd3));
         chk("hit_iren", iREN, 0);
         m_touch(s, w);
         return;
      end
      chk("miss_ihit", ihit, 0);
      chk("miss_iren", iREN, 0);
      v    = m_victim(s);
      mvalid[s][v] = 1'b0;
      base = a & ~(32'(4 * WORDS) - 32'd1);
      beat = 0;
      cyc  = 0;
      while (beat < WORDS && cyc < 500) begin
         @(negedge CLK);
         cyc++;
         if (stall < 0) iwait = ($urandom_range(0, 3) == 0);
         else           iwait = (((cyc - 1) % (stall + 1)) != stall);
         #1;
         chk("fill_iren", iREN, 1);
         chk("fill_iaddr", iaddr, base + 32'(4 * beat));
         chk("fill_ihit", ihit, 0);
         if (!iwait) begin
            beat++;
            if (chg != 0 && beat == 1) begin
               imemaddr = chg;
               imemREN  = 1'b0;
            end
         end
      end
      if (beat < WORDS) chk("fill_timeout", beat, WORDS);
      mvalid[s][v] = 1'b1;
      mtag[s][v]   = tag_of(a);
      m_touch(s, v);
      @(negedge CLK);
      iwait = 1'b0;
      #1;
      if (chg == 0) begin
         chk("refill_hit", ihit, 1);
         chk("refill_data", imemload, mem_word(a & ~32'd3));
         if (stall >= 0) chk("latency", cyc + 1, WORDS * (stall + 1) + 1);
         m_touch(s, v);
      end else begin
         chk("chg_iren", iREN, 0);
         chk("chg_ihit", ihit, 0);
      end
   endtask

   task automatic do_flush(input logic [31:0] a);
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iflush = 1'b1; iwait = 1'b0;
      #1;
      chk("flush_ihit", ihit, 0);
      chk("flush_iren", iREN, 0);
      m_clear();
   endtask

   // Start a miss on a, then abort with iflush (kind 0) or RST (kind 1)
   // during the first fill beat.
   task automatic abort_fill(input logic [31:0] a, input int kind);
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b0;
      #1;
      chk("abort_miss", ihit, 32'(m_lookup(a) >= 0));
      @(negedge CLK);
      if (kind == 0) iflush = 1'b1; else RST = 1'b1;
      #1;
      chk("abort_fill_iren", iREN, 1);
      @(negedge CLK);
      iflush = 1'b0; RST = 1'b0; imemREN = 1'b0;
      #1;
      chk("abort_iren", iREN, 0);
      chk("abort_iaddr", iaddr, 0);
      chk("abort_ihit", ihit, 0);
      m_clear();
   endtask

   initial begin
      logic [31:0] ra;
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0;
      m_clear();
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rst_ihit", ihit, 0);
      chk("rst_iren", iREN, 0);
      chk("rst_iaddr", iaddr, 0);
      chk("rst_imemload", imemload, 0);

      // cold miss, then the neighbouring word hits
      do_fetch(32'h040, 0, 0);
      do_fetch(32'h044, 0, 0);
      // associativity and LRU in set 0
      do_fetch(32'h440, 0, 0);
      do_fetch(32'h040, 0, 0);
      do_fetch(32'h840, 0, 0);
      do_fetch(32'h040, 0, 0);
      do_fetch(32'h440, 0, 0);
      // stalled fill
      do_fetch(32'h1048, 3, 0);
      // flush in idle, then flush during a fill
      do_fetch(32'h040, 0, 0);
      do_flush(32'h040);
      do_fetch(32'h040, 0, 0);
      do_flush(32'h000);
      abort_fill(32'h040, 0);
      do_fetch(32'h040, 0, 0);
      // address change mid-fill
      do_fetch(32'h100, 0, 32'h200);
      do_fetch(32'h200, -1, 0);
      do_fetch(32'h104, -1, 0);
      // reset mid-fill
      abort_fill(32'h300, 1);
      do_fetch(32'h100, -1, 0);
      do_fetch(32'h040, -1, 0);

      // random traffic over a small footprint to force conflicts
      for (int i = 0; i < 200; i++) begin
         ra = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 7)) << 3) |
              (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) do_flush(ra);
         else                            do_fetch(ra, -1, 0);
      end

      @(negedge CLK);
      imemREN = 1'b0; iflush = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
